line_buffer_bram_kxk: RTL and testbench

//  Parametrised K-row BRAM line buffer with a runtime line width and valid/ready streaming.

---
 rtl/line_buffer_bram_kxk_if.sv | 16 +
 rtl/line_buffer_bram_kxk.sv | 80 ++++++++
 tb/tb_line_buffer_bram_kxk.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/line_buffer_bram_kxk_if.sv
// line_buffer_bram_kxk_if: pixel-in / column-out valid-ready stream bundle for the KxK line buffer
interface line_buffer_bram_kxk_if #(
  parameter int DWIDTH = 8,
  parameter int P_CH = 32,
  parameter int IMG_W = 224,
  parameter int K = 3
);
  localparam int BW = DWIDTH * P_CH;
  localparam int AW = $clog2(IMG_W);
  logic s_valid, s_ready, s_last, m_valid, m_ready;
  logic [BW-1:0] s_data;
  logic [K*BW-1:0] m_data;
  logic [AW-1:0] m_col;
  modport master(output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data, m_col);
  modport slave(input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data, m_col);
endinterface

// File: rtl/line_buffer_bram_kxk.sv
// line_buffer_bram_kxk: K-row BRAM line buffer emitting a vertical K-pixel column per accepted beat
module line_buffer_bram_kxk #(
  parameter int DWIDTH = 8,
  parameter int P_CH = 32,
  parameter int IMG_W = 224,
  parameter int K = 3,
  localparam int AW = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW:0]   cfg_width,
  input  logic          frame_start,
  line_buffer_bram_kxk_if.slave bus,
  output logic          err_len
);
  localparam int BW = DWIDTH * P_CH;
  localparam int NB = K - 1;
  localparam int BKW = NB > 1 ? $clog2(NB) : 1;
  localparam int RW = $clog2(K);
  logic [BW-1:0] mem [NB][IMG_W];
  logic [BW-1:0] rd [NB];
  logic [BW-1:0] p1_data;
  logic [AW-1:0] col, c, p1_col;
  logic [RW-1:0] row_cnt, r;
  logic [BKW-1:0] wr_bank, b, p1_bank;
  logic [AW:0] width_q, w, w_cfg;
  logic p1_valid, advance, acc, eol;
  always_comb begin
    w_cfg = (cfg_width == '0 || cfg_width > (AW+1)'(IMG_W)) ? (AW+1)'(IMG_W) : cfg_width;
    w = frame_start ? w_cfg : width_q;
    c = frame_start ? '0 : col;
    r = frame_start ? '0 : row_cnt;
    b = frame_start ? '0 : wr_bank;
    advance = !bus.m_valid || bus.m_ready;
    acc = bus.s_valid && advance;
    eol = {1'b0, c} == w - 1'b1;
  end
  assign bus.s_ready = advance;
  always_ff @(posedge clk)
    if (acc)
      for (int i = 0; i < NB; i++) begin
        rd[i] <= mem[i][c];
        if (b == BKW'(i)) mem[i][c] <= bus.s_data;
      end
  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row_cnt <= '0;
      wr_bank <= '0;
      width_q <= (AW+1)'(IMG_W);
      err_len <= 1'b0;
      p1_valid <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data <= '0;
      bus.m_col <= '0;
    end else begin
      if (frame_start) begin
        col <= '0;
        row_cnt <= '0;
        wr_bank <= '0;
        width_q <= w_cfg;
      end
      if (acc) begin
        col <= eol ? '0 : c + 1'b1;
        row_cnt <= (eol && r != RW'(K-1)) ? r + 1'b1 : r;
        wr_bank <= eol ? (b == BKW'(NB-1) ? '0 : b + 1'b1) : b;
        if (bus.s_last != eol) err_len <= 1'b1;
      end
      if (advance) begin
        p1_valid <= acc && r == RW'(K-1);
        p1_data <= bus.s_data;
        p1_col <= c;
        p1_bank <= b;
        bus.m_valid <= p1_valid;
        bus.m_col <= p1_col;
        for (int i = 0; i < NB; i++) bus.m_data[i*BW +: BW] <= rd[BKW'((int'(p1_bank) + i) % NB)];
        bus.m_data[NB*BW +: BW] <= p1_data;
      end
    end
endmodule

// File: tb/tb_line_buffer_bram_kxk.sv
// tb_line_buffer_bram_kxk: directed raster streams checked against a row/column model of the line buffer
module tb_line_buffer_bram_kxk;
  localparam int DW = 8, PC = 2, IW = 8, K = 3, BW = DW * PC, AW = $clog2(IW);
  typedef struct {
    logic [K*BW-1:0] d;
    logic [AW-1:0] c;
  } exp_t;
  logic clk = 0, rst = 1, frame_start = 0, err_len;
  logic [AW:0] cfg_width = '0;
  int checks = 0, failures = 0, out_n = 0, cyc = 0;
  exp_t q[$];
  logic [K*BW-1:0] first_out = '0, last_out = '0, held = '0;
  logic [AW-1:0] last_col = '0;
  logic [3:0] pat = 4'b1001;
  bit stalled = 0, rdy_mode = 0;
  line_buffer_bram_kxk_if #(.DWIDTH(DW), .P_CH(PC), .IMG_W(IW), .K(K)) bus();
  line_buffer_bram_kxk #(.DWIDTH(DW), .P_CH(PC), .IMG_W(IW), .K(K)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_width(cfg_width),
    .frame_start(frame_start),
    .bus(bus),
    .err_len(err_len)
  );
  always #5 clk = ~clk;
  function automatic logic [BW-1:0] pix(input int y, input int x);
    logic [7:0] p;
    p = {4'(y), 4'(x)};
    return {p ^ 8'hA5, p};
  endfunction
  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic send(input int y, input int x, input bit last, input bit fs);
    bit a;
    a = 0;
    bus.s_valid = 1;
    bus.s_data = pix(y, x);
    bus.s_last = last;
    frame_start = fs;
    for (int n = 0; n < 50 && !a; n++) begin
      @(negedge clk);
      a = bus.s_ready;
      @(posedge clk);
      #1;
      frame_start = 0;
    end
    chk(a, "accept_timeout", 64'(a), 1);
    if (y >= 2) q.push_back('{d: {pix(y, x), pix(y - 1, x), pix(y - 2, x)}, c: AW'(x)});
    bus.s_valid = 0;
    bus.s_last = 0;
  endtask
  task automatic send_frame(input int w, input int rows);
    cfg_width = (AW+1)'(w);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < w; x++) send(y, x, x == w - 1, y == 0 && x == 0);
  endtask
  task automatic drain();
    for (int n = 0; n < 60 && q.size() != 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk(q.size() == 0, "drain", 64'(q.size()), 0);
  endtask
  initial begin
    bus.m_ready = 1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.m_ready = rdy_mode ? pat[cyc % 4] : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst) stalled = 0;
    else begin
      chk(bus.s_ready == !(bus.m_valid && !bus.m_ready), "s_ready_rule", 64'(bus.s_ready), 64'(!(bus.m_valid && !bus.m_ready)));
      if (stalled) chk(bus.m_valid && bus.m_data == held, "stall_hold", 64'(bus.m_data), 64'(held));
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) chk(0, "unexpected_out", 64'(bus.m_data), 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk(bus.m_data == e.d, "col_data", 64'(bus.m_data), 64'(e.d));
          chk(bus.m_col == e.c, "col_index", 64'(bus.m_col), 64'(e.c));
          if (out_n == 0) first_out = bus.m_data;
          last_out = bus.m_data;
          last_col = bus.m_col;
          out_n++;
        end
      end
      stalled = bus.m_valid && !bus.m_ready;
      held = bus.m_data;
    end
  end
  initial begin
    bus.s_valid = 0;
    bus.s_data = '0;
    bus.s_last = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk(bus.m_valid == 0, "rst_m_valid", 64'(bus.m_valid), 0);
    chk(bus.m_data == '0, "rst_m_data", 64'(bus.m_data), 0);
    chk(bus.m_col == '0, "rst_m_col", 64'(bus.m_col), 0);
    chk(err_len == 0, "rst_err_len", 64'(err_len), 0);
    chk(bus.s_ready == 1, "rst_s_ready", 64'(bus.s_ready), 1);
    out_n = 0;
    send_frame(4, 4);
    drain();
    chk(out_n == 8, "s1_count", 64'(out_n), 8);
    chk({first_out[39:32], first_out[23:16], first_out[7:0]} == 24'h201000, "s1_first", 64'({first_out[39:32], first_out[23:16], first_out[7:0]}), 64'h201000);
    rdy_mode = 1;
    out_n = 0;
    send_frame(4, 4);
    drain();
    rdy_mode = 0;
    chk(out_n == 8, "s2_count", 64'(out_n), 8);
    chk(first_out == {pix(2, 0), pix(1, 0), pix(0, 0)}, "s2_first", 64'(first_out), 64'({pix(2, 0), pix(1, 0), pix(0, 0)}));
    out_n = 0;
    send_frame(8, 5);
    drain();
    chk(out_n == 24, "s3_count", 64'(out_n), 24);
    chk({last_out[39:32], last_out[23:16], last_out[7:0]} == 24'h473727, "s3_last", 64'({last_out[39:32], last_out[23:16], last_out[7:0]}), 64'h473727);
    chk(last_col == 7, "s3_last_col", 64'(last_col), 7);
    chk(err_len == 0, "s3_err_len", 64'(err_len), 0);
    out_n = 0;
    cfg_width = 4;
    send(0, 0, 0, 1);
    send(0, 1, 0, 0);
    chk(err_len == 0, "s4_err_before", 64'(err_len), 0);
    send(0, 2, 1, 0);
    chk(err_len == 1, "s4_err_set", 64'(err_len), 1);
    send(0, 3, 0, 0);
    for (int y = 1; y < 3; y++)
      for (int x = 0; x < 4; x++) send(y, x, x == 3, 0);
    drain();
    chk(err_len == 1, "s4_err_sticky", 64'(err_len), 1);
    chk(out_n == 4, "s4_count", 64'(out_n), 4);
    out_n = 0;
    for (int x = 0; x < 4; x++) send(0, x, x == 3, x == 0);
    send(1, 0, 0, 0);
    send(1, 1, 0, 0);
    send_frame(4, 3);
    drain();
    chk(out_n == 4, "s5_count", 64'(out_n), 4);
    chk({first_out[39:32], first_out[23:16], first_out[7:0]} == 24'h201000, "s5_first", 64'({first_out[39:32], first_out[23:16], first_out[7:0]}), 64'h201000);
    cfg_width = 4;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) send(y, x, x == 3, y == 0 && x == 0);
    send(3, 0, 0, 0);
    send(3, 1, 0, 0);
    rst = 1;
    @(posedge clk);
    #1;
    chk(bus.m_valid == 0, "s6_m_valid", 64'(bus.m_valid), 0);
    chk(bus.m_data == '0, "s6_m_data", 64'(bus.m_data), 0);
    chk(bus.m_col == '0, "s6_m_col", 64'(bus.m_col), 0);
    chk(err_len == 0, "s6_err_len", 64'(err_len), 0);
    q.delete();
    rst = 0;
    out_n = 0;
    send_frame(4, 4);
    drain();
    chk(out_n == 8, "s6_count", 64'(out_n), 8);
    chk({first_out[39:32], first_out[23:16], first_out[7:0]} == 24'h201000, "s6_first", 64'({first_out[39:32], first_out[23:16], first_out[7:0]}), 64'h201000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
